clock_time_ctrl: RTL and testbench

//   Mode/time-set controller for the digital clock datapath. Sequences the seconds

---
 rtl/clock_time_ctrl_if.sv | 27 ++
 rtl/clock_time_ctrl.sv | 150 +++++++++++++++
 tb/tb_clock_time_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_time_ctrl_if.sv
// Signal bundle between prescaler/keys/counters and the clock mode/time-set controller.
// The controller takes the slave side; whoever drives ticks, keys and carries takes master.
interface clock_time_ctrl_if;
  logic       tick_1hz;
  logic       tick_blink;
  logic       key_mode;
  logic       key_adj;
  logic       sec_co;
  logic       min_co;
  logic       en_sec;
  logic       en_min;
  logic       en_hr;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blank_hr;
  logic       blank_min;

  modport master (
    output tick_1hz, tick_blink, key_mode, key_adj, sec_co, min_co,
    input  en_sec, en_min, en_hr, sec_clr, mode, blank_hr, blank_min
  );

  modport slave (
    input  tick_1hz, tick_blink, key_mode, key_adj, sec_co, min_co,
    output en_sec, en_min, en_hr, sec_clr, mode, blank_hr, blank_min
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Clock mode/time-set controller: debounced MODE/ADJ keys step RUN->SET_HR->SET_MIN->SET_SEC.
// Outputs are combinational from state (0 cycles); no backpressure, inputs sampled every CP.
module clock_time_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd50000,
  parameter int unsigned REP_DELAY  = 4,
  parameter int unsigned REP_RATE   = 1,
  parameter int unsigned TIMEOUT_S  = 30
) (
  input logic              CP,
  input logic              CR,
  clock_time_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } state_t;

  localparam int REP_W = $clog2(REP_DELAY + 1);
  localparam int TO_W  = $clog2(TIMEOUT_S + 1);

  // Bit 0 is the MODE key, bit 1 the ADJ key.
  logic [1:0]  key_raw;
  logic [1:0]  key_s1;
  logic [1:0]  key_s2;
  logic [1:0]  key_lvl;
  logic [1:0]  key_lvl_d;
  logic [19:0] deb_cnt [2];

  logic             mode_evt;
  logic             adj_rise;
  logic             adj_held;
  logic             rep_evt;
  logic             adj_evt;
  logic             adj_eff;
  logic             key_evt;
  logic [REP_W-1:0] rep_cnt;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            phase;

  logic en_sec_c;
  logic en_min_c;
  logic en_hr_c;
  logic sec_clr_c;

  assign key_raw = {bus.key_adj, bus.key_mode};

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      key_s1     <= '0;
      key_s2     <= '0;
      key_lvl    <= '0;
      key_lvl_d  <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      rep_cnt    <= '0;
    end else begin
      key_s1    <= key_raw;
      key_s2    <= key_s1;
      key_lvl_d <= key_lvl;
      // Any sample agreeing with the accepted level restarts the hold count.
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] == key_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_CYCLES - 20'd1) begin
          key_lvl[i] <= key_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
      if (!adj_held) begin
        rep_cnt <= '0;
      end else if (bus.tick_blink) begin
        rep_cnt <= rep_evt ? REP_W'(REP_DELAY - REP_RATE) : rep_cnt + REP_W'(1);
      end
    end
  end

  assign mode_evt = key_lvl[0] & ~key_lvl_d[0];
  assign adj_rise = key_lvl[1] & ~key_lvl_d[1];
  assign adj_held = key_lvl[1];
  assign rep_evt  = adj_held & bus.tick_blink & (rep_cnt >= REP_W'(REP_DELAY - 1));
  assign adj_evt  = adj_rise | rep_evt;
  // A MODE event swallows a same-cycle ADJ event so no enable fires on the way out.
  assign adj_eff  = adj_evt & ~mode_evt;
  assign key_evt  = mode_evt | adj_evt;

  assign to_hit = (state != RUN) & bus.tick_1hz & (to_cnt == TO_W'(TIMEOUT_S - 1));

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state  <= RUN;
      to_cnt <= '0;
      phase  <= 1'b0;
    end else begin
      if (to_hit) begin
        state <= RUN;
      end else if (mode_evt) begin
        case (state)
          RUN:     state <= SET_HR;
          SET_HR:  state <= SET_MIN;
          SET_MIN: state <= SET_SEC;
          default: state <= RUN;
        endcase
      end
      if (state == RUN || to_hit || key_evt) begin
        to_cnt <= '0;
      end else if (bus.tick_1hz) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (to_hit || mode_evt) begin
        phase <= 1'b0;
      end else if (bus.tick_blink) begin
        phase <= ~phase;
      end
    end
  end

  always_comb begin
    en_sec_c  = 1'b0;
    en_min_c  = 1'b0;
    en_hr_c   = 1'b0;
    sec_clr_c = 1'b0;
    case (state)
      RUN: begin
        en_sec_c = bus.tick_1hz;
        en_min_c = bus.tick_1hz & bus.sec_co;
        en_hr_c  = bus.tick_1hz & bus.sec_co & bus.min_co;
      end
      SET_HR:  en_hr_c   = adj_eff;
      SET_MIN: en_min_c  = adj_eff;
      default: sec_clr_c = adj_eff;
    endcase
  end

  assign bus.en_sec    = ~CR & en_sec_c;
  assign bus.en_min    = ~CR & en_min_c;
  assign bus.en_hr     = ~CR & en_hr_c;
  assign bus.sec_clr   = ~CR & sec_clr_c;
  assign bus.mode      = state;
  assign bus.blank_hr  = ~CR & (state == SET_HR) & phase & ~adj_held;
  assign bus.blank_min = ~CR & (state == SET_MIN) & phase & ~adj_held;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: RUN vector table plus hand-written key/timeout/reset sequences.
module tb_clock_time_ctrl;
  logic CP = 1'b0;
  logic CR = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(
    .DEB_CYCLES(20'd4),
    .REP_DELAY (2),
    .REP_RATE  (1),
    .TIMEOUT_S (3)
  ) dut (
    .CP (CP),
    .CR (CR),
    .bus(bus)
  );

  always #5 CP = ~CP;

  // exp = {en_sec, en_min, en_hr, sec_clr, mode[1:0], blank_hr, blank_min}
  typedef struct {
    logic       t1;
    logic       sc;
    logic       mc;
    logic       tb;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  function automatic logic [7:0] outs();
    return {bus.en_sec, bus.en_min, bus.en_hr, bus.sec_clr, bus.mode, bus.blank_hr, bus.blank_min};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press_mode();
    bus.key_mode = 1'b1;
    idle(10);
    bus.key_mode = 1'b0;
    idle(10);
  endtask

  task automatic pulse_blink();
    bus.tick_blink = 1'b1;
    step();
    bus.tick_blink = 1'b0;
  endtask

  task automatic run_count(input int n, output int ns, output int nm, output int nh, output int nc);
    ns = 0; nm = 0; nh = 0; nc = 0;
    for (int c = 0; c < n; c++) begin
      #2;
      ns += int'(bus.en_sec);
      nm += int'(bus.en_min);
      nh += int'(bus.en_hr);
      nc += int'(bus.sec_clr);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int ns, nm, nh, nc;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b1000_0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'b1100_0000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'b1110_0000};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'b1000_0000};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'b1110_0000};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0000};

    bus.tick_1hz   = 1'b1;
    bus.tick_blink = 1'b0;
    bus.key_mode   = 1'b0;
    bus.key_adj    = 1'b0;
    bus.sec_co     = 1'b1;
    bus.min_co     = 1'b1;
    #2;
    chk("reset_outputs", int'(outs()), 0);

    @(posedge CP);
    @(posedge CP);
    #1;
    CR = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.sec_co   = 1'b0;
    bus.min_co   = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.tick_1hz   = vecs[i].t1;
      bus.sec_co     = vecs[i].sc;
      bus.min_co     = vecs[i].mc;
      bus.tick_blink = vecs[i].tb;
      sb.push_back(vecs[i]);
      #2;
      e = sb.pop_front();
      chk($sformatf("run_vec%0d", i), int'(outs()), int'(e.exp));
      step();
    end
    bus.tick_1hz   = 1'b0;
    bus.tick_blink = 1'b0;
    bus.sec_co     = 1'b0;
    bus.min_co     = 1'b0;
    idle(2);

    // MODE bounce 1-0-1 then steady: one event, late enough that the bounce restarted debounce.
    bus.key_mode = 1'b1;
    step();
    bus.key_mode = 1'b0;
    step();
    bus.key_mode = 1'b1;
    idle(6);
    #2;
    chk("bounce_not_early", int'(bus.mode), 0);
    step();
    idle(4);
    #2;
    chk("bounce_mode_set_hr", int'(bus.mode), 1);
    step();
    idle(15);
    #2;
    chk("bounce_single_event", int'(bus.mode), 1);
    step();
    bus.key_mode = 1'b0;
    idle(10);

    pulse_blink();
    #2;
    chk("set_hr_blank_on", int'({bus.blank_hr, bus.blank_min}), 2);
    step();
    pulse_blink();
    #2;
    chk("set_hr_blank_off", int'(bus.blank_hr), 0);
    step();

    // ADJ held in SET_HR: press event, then repeats at blink ticks 2, 3 and 4.
    bus.key_adj = 1'b1;
    nh = 0;
    for (int c = 0; c < 25; c++) begin
      bus.tick_blink = (c == 12 || c == 15 || c == 18 || c == 21);
      #2;
      nh += int'(bus.en_hr);
      if (c == 12) chk("adj_tick1_no_repeat", int'(bus.en_hr), 0);
      if (c == 15) chk("adj_tick2_repeat", int'(bus.en_hr), 1);
      if (c == 18) chk("adj_tick3_repeat", int'(bus.en_hr), 1);
      if (c == 21) chk("adj_tick4_repeat", int'(bus.en_hr), 1);
      if (c == 13 || c == 16) chk("adj_held_no_blank", int'(bus.blank_hr), 0);
      step();
    end
    bus.tick_blink = 1'b0;
    chk("adj_hold_en_hr_total", nh, 4);
    chk("set_hr_frozen_min_sec", int'({bus.en_sec, bus.en_min}), 0);
    bus.key_adj = 1'b0;
    idle(12);

    // MODE and ADJ debounce together: MODE wins, ADJ dropped.
    bus.key_mode = 1'b1;
    bus.key_adj  = 1'b1;
    run_count(15, ns, nm, nh, nc);
    chk("mode_adj_same_en_hr", nh, 0);
    #2;
    chk("mode_adj_same_mode", int'(bus.mode), 2);
    step();
    bus.key_mode = 1'b0;
    bus.key_adj  = 1'b0;
    idle(12);

    bus.key_adj = 1'b1;
    run_count(12, ns, nm, nh, nc);
    chk("set_min_en_min", nm, 1);
    chk("set_min_no_hr_carry", nh, 0);
    bus.key_adj = 1'b0;
    idle(12);

    press_mode();
    #2;
    chk("mode_set_sec", int'(bus.mode), 3);
    step();
    bus.tick_1hz = 1'b1;
    #2;
    chk("set_sec_tick_frozen", int'({bus.en_sec, bus.en_min, bus.en_hr}), 0);
    step();
    bus.tick_1hz = 1'b0;
    bus.key_adj  = 1'b1;
    run_count(12, ns, nm, nh, nc);
    chk("set_sec_clr_pulse", nc, 1);
    chk("set_sec_no_en_sec", ns, 0);
    bus.key_adj = 1'b0;
    idle(12);

    // MODE back to RUN with ticks straddling the transition; ticks while still in SET_SEC ignored.
    bus.key_mode = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bus.tick_1hz = (c == 5 || c == 6 || c == 12);
      #2;
      if (c == 5 || c == 6) chk($sformatf("sec_to_run_tick_c%0d", c), int'(bus.en_sec), 0);
      if (c == 12) chk("run_after_set_sec", int'({bus.mode, bus.en_sec}), 1);
      step();
    end
    bus.tick_1hz = 1'b0;
    bus.key_mode = 1'b0;
    idle(10);

    press_mode();
    press_mode();
    #2;
    chk("mode_set_min", int'(bus.mode), 2);
    step();
    pulse_blink();
    #2;
    chk("set_min_blank_on", int'({bus.blank_hr, bus.blank_min}), 1);
    step();

    // No keys in SET_MIN: third tick_1hz returns to RUN next cycle.
    for (int c = 0; c < 9; c++) begin
      bus.tick_1hz = (c == 0 || c == 3 || c == 6);
      #2;
      if (c == 4) chk("timeout_not_yet", int'(bus.mode), 2);
      if (c == 7) chk("timeout_to_run", int'({bus.mode, bus.blank_min}), 0);
      step();
    end
    bus.tick_1hz = 1'b0;

    press_mode();
    #2;
    chk("mode_set_hr_again", int'(bus.mode), 1);
    step();
    bus.key_adj = 1'b1;
    idle(12);
    pulse_blink();
    #2;
    CR = 1'b1;
    #1;
    chk("reset_mid_set_mode", int'(bus.mode), 0);
    bus.tick_1hz = 1'b1;
    #1;
    chk("reset_forces_outputs", int'(outs()), 0);
    step();
    step();
    CR = 1'b0;
    bus.tick_1hz = 1'b0;
    idle(12);
    #2;
    chk("after_reset_run", int'(bus.mode), 0);
    step();
    bus.tick_1hz = 1'b1;
    #2;
    chk("after_reset_en_sec", int'(bus.en_sec), 1);
    step();
    bus.tick_1hz = 1'b0;
    bus.key_adj  = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
